uart_rx_frame_deserializer: RTL and testbench
=============================================

UART_RX_FRAME_DESERIALIZER -- requirements
Module: uart_rx_frame_deserializer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter: MAX_WIDTH, default 8, widest data word supported (legal range 5..16).
REQ-003 Derived constant: LEN_W = clog2(MAX_WIDTH+1).
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 Frame_Start  input  1  one-cycle pulse; begins a new frame and latches its configuration.
REQ-007 Deser_En  input  1  sample strobe; Sampled_Bit is valid in this cycle.
REQ-008 Sampled_Bit  input  1  received serial bit.
REQ-009 Data_Len  input  LEN_W  data bits per frame.
REQ-010 MSB_First  input  1  1 = first received bit is the word MSB.
REQ-011 Par_En  input  1  1 = one parity bit follows the data bits.
REQ-012 Par_Odd  input  1  1 = odd parity, 0 = even parity.
REQ-013 P_Ready  input  1  consumer accepts P_DATA.
REQ-014 P_DATA  output  MAX_WIDTH  assembled word, right-aligned, unused MSBs zero.
REQ-015 P_Valid  output  1  P_DATA and Par_Err hold a valid word.
REQ-016 Par_Err  output  1  parity mismatch for the word on P_DATA.
REQ-017 Overrun  output  1  one-cycle pulse when a completed word is dropped.
REQ-018 Busy  output  1  high while in DATA or PARITY.

Function
REQ-019 FSM states SHALL be IDLE, DATA and PARITY.
REQ-020 Frame_Start in any state SHALL latch Data_Len, MSB_First, Par_En and Par_Odd, clear the bit counter and shift register, and enter DATA.
REQ-021 A latched Data_Len of 0 or above MAX_WIDTH SHALL be clamped to MAX_WIDTH.
REQ-022 If Frame_Start and Deser_En are high in the same cycle, Frame_Start SHALL win and the bit SHALL be discarded.
REQ-023 Deser_En in IDLE SHALL be ignored.
REQ-024 In DATA, the k-th strobed bit (k = 0..len-1) SHALL be stored at position k when LSB-first, or at position len-1-k when MSB-first.
REQ-025 The bit counter SHALL increment on each strobe in DATA.
REQ-026 On the len-th data bit the FSM SHALL go to PARITY if Par_En is latched, otherwise complete the frame.
REQ-027 In PARITY, on the strobe, error = (XOR of data bits XOR parity bit) != Par_Odd; the frame then completes.
REQ-028 Completion SHALL return the FSM to IDLE and, one cycle after the final strobe, present the word on P_DATA with Par_Err (0 when parity is disabled) and P_Valid = 1.
REQ-029 P_Valid SHALL stay high until a clock edge at which P_Ready = 1.
REQ-030 P_DATA and Par_Err SHALL remain stable while P_Valid = 1.
REQ-031 A completion while P_Valid = 1 and P_Ready = 0 SHALL drop the new word, keep the held word, and pulse Overrun for one cycle.
REQ-032 A completion in the same cycle as a P_Valid & P_Ready acceptance SHALL load the new word, keep P_Valid = 1, and not assert Overrun.
REQ-033 Frame_Start during DATA or PARITY SHALL abandon the partial frame silently, with no Overrun and no output change.

Reset
REQ-034 RST SHALL set the FSM to IDLE, clear the counter and shift register, and drive P_DATA = 0, P_Valid = 0, Par_Err = 0, Overrun = 0 and Busy = 0.
REQ-035 RST SHALL override all other inputs in the same cycle, including a reset asserted mid-frame.
REQ-036 Latched configuration after reset SHALL be MAX_WIDTH, LSB-first, parity off.

Verification
REQ-037 Scenario: len=8, LSB-first, no parity, bits 1,0,1,0,0,1,0,1 -> P_DATA = 0xA5, P_Valid = 1 one cycle after the 8th strobe, Par_Err = 0.
REQ-038 Scenario: len=8, MSB-first, same bits -> P_DATA = 0xA5; len=5, LSB-first, bits 1,1,0,0,1 -> P_DATA = 0x13, upper bits 0.
REQ-039 Scenario: len=7, even parity, data 0x41, parity bit 0 -> Par_Err = 0; same frame with parity bit 1 -> Par_Err = 1; odd parity with bit 1 -> Par_Err = 0.
REQ-040 Scenario: P_Ready held 0 and two frames 0x11 then 0x22 completed -> P_DATA stays 0x11 and Overrun pulses once; then P_Ready = 1 -> P_Valid falls next cycle.
REQ-041 Scenario: Frame_Start after 3 data bits, then a full 0x3C frame -> P_DATA = 0x3C with no Overrun; Frame_Start with Deser_En in the same cycle -> that bit is not counted.
REQ-042 Scenario: RST asserted after 4 bits with P_Valid = 1 -> next cycle all outputs 0 and Busy = 0; later strobes without Frame_Start produce no output.

Source files
------------

// File: rtl/uart_rx_frame_deserializer_if.sv
// Bundle of the deserializer's frame-control, serial-strobe and parallel-output handshake signals.
// The master side drives frames in and consumes words; the slave side is the deserializer.
interface uart_rx_frame_deserializer_if #(
    parameter int MAX_WIDTH = 8,
    parameter int LEN_W     = $clog2(MAX_WIDTH + 1)
);
    logic                 Frame_Start;
    logic                 Deser_En;
    logic                 Sampled_Bit;
    logic [LEN_W-1:0]     Data_Len;
    logic                 MSB_First;
    logic                 Par_En;
    logic                 Par_Odd;
    logic                 P_Ready;
    logic [MAX_WIDTH-1:0] P_DATA;
    logic                 P_Valid;
    logic                 Par_Err;
    logic                 Overrun;
    logic                 Busy;

    modport master (
        output Frame_Start, Deser_En, Sampled_Bit, Data_Len, MSB_First, Par_En, Par_Odd, P_Ready,
        input  P_DATA, P_Valid, Par_Err, Overrun, Busy
    );

    modport slave (
        input  Frame_Start, Deser_En, Sampled_Bit, Data_Len, MSB_First, Par_En, Par_Odd, P_Ready,
        output P_DATA, P_Valid, Par_Err, Overrun, Busy
    );
endinterface

// File: rtl/uart_rx_frame_deserializer.sv
// Assembles strobed UART data bits (LSB- or MSB-first, optional parity) into a right-aligned
// parallel word held in a one-deep valid/ready output register with overrun detection.
module uart_rx_frame_deserializer #(
    parameter int MAX_WIDTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    uart_rx_frame_deserializer_if.slave   bus
);
    localparam int LEN_W = $clog2(MAX_WIDTH + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 msb_q, msb_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [MAX_WIDTH-1:0] shift_q, shift_d;
    logic [MAX_WIDTH-1:0] pdata_q, pdata_d;
    logic                 pvalid_q, pvalid_d;
    logic                 perr_q, perr_d;
    logic                 overrun_q, overrun_d;

    logic                 done;
    logic [MAX_WIDTH-1:0] done_word;
    logic                 done_err;
    logic [LEN_W-1:0]     bit_pos;
    logic [MAX_WIDTH-1:0] bit_sel;

    // Destination of the current data bit; the counter never reaches len, so MSB-first stays in range.
    assign bit_pos = msb_q ? (len_q - LEN_W'(1) - cnt_q) : cnt_q;

    for (genvar gi = 0; gi < MAX_WIDTH; gi++) begin : g_bit_sel
        assign bit_sel[gi] = (bit_pos == LEN_W'(gi));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            len_q     <= LEN_MAX;
            msb_q     <= 1'b0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            cnt_q     <= '0;
            shift_q   <= '0;
            pdata_q   <= '0;
            pvalid_q  <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            msb_q     <= msb_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            pdata_q   <= pdata_d;
            pvalid_q  <= pvalid_d;
            perr_q    <= perr_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        msb_d     = msb_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        pdata_d   = pdata_q;
        pvalid_d  = pvalid_q;
        perr_d    = perr_q;
        overrun_d = 1'b0;
        done      = 1'b0;
        done_word = shift_q;
        done_err  = 1'b0;

        // A new frame always wins, discarding any partial frame and any same-cycle strobe.
        if (bus.Frame_Start) begin
            len_d     = (bus.Data_Len == '0 || bus.Data_Len > LEN_MAX) ? LEN_MAX : bus.Data_Len;
            msb_d     = bus.MSB_First;
            par_en_d  = bus.Par_En;
            par_odd_d = bus.Par_Odd;
            cnt_d     = '0;
            shift_d   = '0;
            state_d   = DATA;
        end else begin
            case (state_q)
                DATA: begin
                    if (bus.Deser_En) begin
                        shift_d = (shift_q & ~bit_sel) | (bit_sel & {MAX_WIDTH{bus.Sampled_Bit}});
                        cnt_d   = cnt_q + LEN_W'(1);
                        if (cnt_q + LEN_W'(1) == len_q) begin
                            if (par_en_q) begin
                                state_d = PARITY;
                            end else begin
                                state_d   = IDLE;
                                done      = 1'b1;
                                done_word = shift_d;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (bus.Deser_En) begin
                        state_d  = IDLE;
                        done     = 1'b1;
                        done_err = ((^shift_q) ^ bus.Sampled_Bit) != par_odd_q;
                    end
                end
                default: ;
            endcase
        end

        // Output holding register: an acceptance on this edge frees the slot for a completing word.
        if (done) begin
            if (pvalid_q && !bus.P_Ready) begin
                overrun_d = 1'b1;
            end else begin
                pdata_d  = done_word;
                perr_d   = done_err;
                pvalid_d = 1'b1;
            end
        end else if (pvalid_q && bus.P_Ready) begin
            pvalid_d = 1'b0;
        end
    end

    assign bus.P_DATA  = pdata_q;
    assign bus.P_Valid = pvalid_q;
    assign bus.Par_Err = perr_q;
    assign bus.Overrun = overrun_q;
    assign bus.Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_deserializer.sv
// Directed bench for uart_rx_frame_deserializer: stimulus pushes expected words to a scoreboard
// queue, a negedge monitor pops and compares every newly presented word.
module tb_uart_rx_frame_deserializer;
    localparam int MAX_WIDTH = 8;
    localparam int LEN_W     = $clog2(MAX_WIDTH + 1);

    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_rx_frame_deserializer_if #(.MAX_WIDTH(MAX_WIDTH), .LEN_W(LEN_W)) bus ();

    uart_rx_frame_deserializer #(.MAX_WIDTH(MAX_WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int ov_cnt   = 0;
    logic [8:0] sb[$];
    logic last_valid = 1'b0;
    logic last_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: a word is new when valid appears or when the previous one was accepted.
    always @(negedge CLK) begin
        logic [8:0] exp_w;
        if (!RST) begin
            if (bus.P_Valid && (!last_valid || last_ready)) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_word", 32'(sb.size()), 32'd1);
                end else begin
                    exp_w = sb.pop_front();
                    check("sb_p_data", 32'(bus.P_DATA), 32'(exp_w[7:0]));
                    check("sb_par_err", 32'(bus.Par_Err), 32'(exp_w[8]));
                    $display("word: P_DATA=%02h Par_Err=%0b expected %02h/%0b",
                             bus.P_DATA, bus.Par_Err, exp_w[7:0], exp_w[8]);
                end
            end
            if (bus.Overrun) ov_cnt++;
        end
        last_valid = bus.P_Valid;
        last_ready = bus.P_Ready;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input int len, input logic msb, input logic pen, input logic podd,
                         input logic strobe_too, input logic b);
        bus.Frame_Start = 1'b1;
        bus.Data_Len    = LEN_W'(len);
        bus.MSB_First   = msb;
        bus.Par_En      = pen;
        bus.Par_Odd     = podd;
        bus.Deser_En    = strobe_too;
        bus.Sampled_Bit = b;
        tick();
        bus.Frame_Start = 1'b0;
        bus.Deser_En    = 1'b0;
    endtask

    task automatic strobe(input logic b);
        bus.Deser_En    = 1'b1;
        bus.Sampled_Bit = b;
        tick();
        bus.Deser_En    = 1'b0;
    endtask

    // seq[k] is the k-th bit on the wire.
    task automatic send_bits(input logic [15:0] seq, input int n);
        for (int k = 0; k < n; k++) strobe(seq[k]);
    endtask

    initial begin
        bus.Frame_Start = 1'b0;
        bus.Deser_En    = 1'b0;
        bus.Sampled_Bit = 1'b0;
        bus.Data_Len    = '0;
        bus.MSB_First   = 1'b0;
        bus.Par_En      = 1'b0;
        bus.Par_Odd     = 1'b0;
        bus.P_Ready     = 1'b1;
        RST = 1'b1;
        tick();
        tick();
        check("rst_p_valid", 32'(bus.P_Valid), 32'd0);
        check("rst_p_data", 32'(bus.P_DATA), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        RST = 1'b0;
        tick();

        // len 8 LSB-first 0xA5, valid one cycle after the final strobe
        start(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("busy_in_data", 32'(bus.Busy), 32'd1);
        sb.push_back({1'b0, 8'hA5});
        send_bits(16'h00A5, 7);
        check("no_valid_before_last", 32'(bus.P_Valid), 32'd0);
        strobe(1'b1);
        check("lsb_valid_timing", 32'(bus.P_Valid), 32'd1);
        check("lsb_data", 32'(bus.P_DATA), 32'hA5);
        check("idle_after_done", 32'(bus.Busy), 32'd0);
        tick();

        // MSB-first, same wire bits
        start(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back({1'b0, 8'hA5});
        send_bits(16'h00A5, 8);
        tick();

        // MSB-first asymmetric: len 6, wire 1,1,0,1,0,0 -> 0x34
        start(6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back({1'b0, 8'h34});
        send_bits(16'h000B, 6);
        tick();

        // len 5 LSB-first 1,1,0,0,1 -> 0x13
        start(5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back({1'b0, 8'h13});
        send_bits(16'h0013, 5);
        check("len5_upper_zero", 32'(bus.P_DATA), 32'h13);
        tick();

        // Data_Len 0 clamps to 8
        start(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back({1'b0, 8'hC3});
        send_bits(16'h00C3, 7);
        check("clamp_not_done_at_7", 32'(bus.Busy), 32'd1);
        strobe(1'b1);
        tick();

        // Parity: len 7 data 0x41
        start(7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sb.push_back({1'b0, 8'h41});
        send_bits(16'h0041, 7);
        check("busy_in_parity", 32'(bus.Busy), 32'd1);
        strobe(1'b0);
        tick();
        start(7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sb.push_back({1'b1, 8'h41});
        send_bits(16'h0041, 7);
        strobe(1'b1);
        check("even_par_err", 32'(bus.Par_Err), 32'd1);
        tick();
        start(7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        sb.push_back({1'b0, 8'h41});
        send_bits(16'h0041, 7);
        strobe(1'b1);
        tick();

        // Overrun: 0x11 held, 0x22 dropped
        bus.P_Ready = 1'b0;
        start(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back({1'b0, 8'h11});
        send_bits(16'h0011, 8);
        start(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(16'h0022, 8);
        check("overrun_pulse", 32'(bus.Overrun), 32'd1);
        check("overrun_keeps_word", 32'(bus.P_DATA), 32'h11);
        tick();
        check("overrun_one_cycle", 32'(bus.Overrun), 32'd0);
        check("overrun_count", 32'(ov_cnt), 32'd1);
        check("held_valid", 32'(bus.P_Valid), 32'd1);
        bus.P_Ready = 1'b1;
        tick();
        check("valid_falls_after_ready", 32'(bus.P_Valid), 32'd0);

        // Completion coinciding with acceptance: new word loads, no overrun
        bus.P_Ready = 1'b0;
        start(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back({1'b0, 8'h12});
        send_bits(16'h0012, 8);
        start(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back({1'b0, 8'h34});
        send_bits(16'h0034, 7);
        bus.P_Ready = 1'b1;
        strobe(1'b0);
        check("accept_and_load_data", 32'(bus.P_DATA), 32'h34);
        check("accept_and_load_valid", 32'(bus.P_Valid), 32'd1);
        check("accept_and_load_no_ovr", 32'(bus.Overrun), 32'd0);
        tick();

        // Abandoned partial frame, then 0x3C
        start(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(16'h0007, 3);
        start(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abandon_no_output", 32'(bus.P_Valid), 32'd0);
        sb.push_back({1'b0, 8'h3C});
        send_bits(16'h003C, 8);
        check("abandon_data", 32'(bus.P_DATA), 32'h3C);
        tick();

        // Frame_Start with a same-cycle strobe: that bit must not count
        start(8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        sb.push_back({1'b0, 8'h5A});
        send_bits(16'h005A, 8);
        check("fs_strobe_discarded", 32'(bus.P_DATA), 32'h5A);
        tick();
        check("overrun_count_final", 32'(ov_cnt), 32'd1);

        // Reset mid-frame while a word is held
        bus.P_Ready = 1'b0;
        start(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back({1'b0, 8'h77});
        send_bits(16'h0077, 8);
        start(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(16'h000F, 4);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst_p_valid", 32'(bus.P_Valid), 32'd0);
        check("midrst_p_data", 32'(bus.P_DATA), 32'd0);
        check("midrst_par_err", 32'(bus.Par_Err), 32'd0);
        check("midrst_overrun", 32'(bus.Overrun), 32'd0);
        check("midrst_busy", 32'(bus.Busy), 32'd0);
        bus.P_Ready = 1'b1;
        send_bits(16'hFFFF, 10);
        check("idle_ignores_strobes", 32'(bus.P_Valid), 32'd0);
        tick();
        tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
